// File: rtl/grid_map.sv
// grid_map: 4-bit cell store for a snake game with a clear sweep, a game-logic rect port and a VGA read port
// Parameters: GRID_SIZE_X columns (32), GRID_SIZE_Y rows (24); cell index = {y[4:0], x[4:0]}
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear               restart the clear sweep at index 0
//   rect_write_in       {x[35:20], y[19:4], func[3:0]} written every IDLE cycle when in range
//   rect_read_addr      {x[31:16], y[15:0]}; rect_read_func one cycle later (ROCK when out of range)
//   vga_cell_x/y        display read; vga_cell_func one cycle later (NULL when out of range)
//   busy                high while the sweep runs
// Optional macro GRID_MAP_BORDER_ROCK_EN: the sweep paints the outer ring with ROCK instead of NULL.
module grid_map #(
   parameter int GRID_SIZE_X = 32,
   parameter int GRID_SIZE_Y = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic [35:0] rect_write_in,
   input  logic [31:0] rect_read_addr,
   output logic [3:0]  rect_read_func,
   input  logic [4:0]  vga_cell_x,
   input  logic [4:0]  vga_cell_y,
   output logic [3:0]  vga_cell_func,
   output logic        busy
);
   localparam int CELLS = GRID_SIZE_X * GRID_SIZE_Y;
   localparam logic [15:0] GX = 16'(GRID_SIZE_X);
   localparam logic [15:0] GY = 16'(GRID_SIZE_Y);
   localparam logic [9:0] LAST = 10'(CELLS - 1);
   localparam logic [3:0] NULL_C = 4'b0000;
   localparam logic [3:0] ROCK_C = 4'b0010;
   typedef enum logic {SWEEP, IDLE} state_t;
   state_t state, state_nx;
   logic [9:0] idx, idx_nx;
   logic [3:0] mem [CELLS];
   logic [3:0] sweep_func;
   logic [15:0] wx, wy, rx, ry;
   logic [3:0] wf;
   logic w_ok, r_ok, v_ok, sweeping, idle_we, we;
   logic [9:0] w_idx, r_idx, v_idx, waddr;
   logic [3:0] wdata;
   assign sweeping = state == SWEEP;
   assign busy = sweeping;
   assign {wx, wy, wf} = rect_write_in;
   assign {rx, ry} = rect_read_addr;
   // full 16-bit compares so aliased upper bits never reach the array
   assign w_ok = wx < GX && wy < GY;
   assign r_ok = rx < GX && ry < GY;
   assign v_ok = {11'd0, vga_cell_x} < GX && {11'd0, vga_cell_y} < GY;
   assign w_idx = {wy[4:0], wx[4:0]};
   assign r_idx = {ry[4:0], rx[4:0]};
   assign v_idx = {vga_cell_y, vga_cell_x};
`ifdef GRID_MAP_BORDER_ROCK_EN
   assign sweep_func = (idx[4:0] == 5'd0 || idx[4:0] == 5'(GRID_SIZE_X - 1) ||
                        idx[9:5] == 5'd0 || idx[9:5] == 5'(GRID_SIZE_Y - 1)) ? ROCK_C : NULL_C;
`else
   assign sweep_func = NULL_C;
`endif
   assign idle_we = !sweeping && w_ok;
   assign we = sweeping || idle_we;
   assign waddr = sweeping ? idx : w_idx;
   assign wdata = sweeping ? sweep_func : wf;
   always_comb begin
      state_nx = state;
      idx_nx = idx;
      if (sweeping) begin
         idx_nx = (clear || idx == LAST) ? '0 : idx + 10'd1;
         state_nx = (!clear && idx == LAST) ? IDLE : SWEEP;
      end else if (clear) begin
         state_nx = SWEEP;
         idx_nx = '0;
      end
   end
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   // rect port is write-first against the IDLE write; vga port sees the old contents
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= SWEEP;
         idx <= '0;
         rect_read_func <= '0;
         vga_cell_func <= '0;
      end else begin
         state <= state_nx;
         idx <= idx_nx;
         rect_read_func <= !r_ok ? ROCK_C : sweeping ? NULL_C : (idle_we && w_idx == r_idx) ? wf : mem[r_idx];
         vga_cell_func <= v_ok ? mem[v_idx] : NULL_C;
      end
endmodule

// File: tb/tb_grid_map.sv
// tb_grid_map: scoreboard bench for grid_map
module tb_grid_map;
   localparam logic [3:0] NUL = 4'd0, SNAKE = 4'd1, ROCK = 4'd2, SNACK = 4'd4;
`ifdef GRID_MAP_BORDER_ROCK_EN
   localparam logic [3:0] BORDER = ROCK;
`else
   localparam logic [3:0] BORDER = NUL;
`endif
   localparam logic [35:0] NOWR = {16'hFFFF, 16'hFFFF, 4'h0};
   typedef struct {
      string nm;
      logic [3:0] er;
      logic [3:0] ev;
      bit cv;
   } exp_t;
   logic clk = 0, rst_n = 0, clear = 0, busy;
   logic [35:0] rect_write_in = NOWR;
   logic [31:0] rect_read_addr = '0;
   logic [4:0] vga_cell_x = '0, vga_cell_y = '0;
   logic [3:0] rect_read_func, vga_cell_func;
   exp_t sb[$];
   bit pend = 0, pend_q = 0;
   int checks = 0, errors = 0;
   int n;
   grid_map dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .rect_write_in(rect_write_in),
      .rect_read_addr(rect_read_addr), .rect_read_func(rect_read_func),
      .vga_cell_x(vga_cell_x), .vga_cell_y(vga_cell_y), .vga_cell_func(vga_cell_func),
      .busy(busy)
   );
   always #5 clk = ~clk;
   always @(posedge clk) pend_q <= pend;
   function automatic logic [35:0] wr(input int x, input int y, input logic [3:0] f);
      return {16'(x), 16'(y), f};
   endfunction
   function automatic logic [31:0] ad(input int x, input int y);
      return {16'(x), 16'(y)};
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, act, exp);
      end
   endtask
   // monitor: one registered response per issued vector, compared one cycle later
   always @(negedge clk)
      if (pend_q) begin
         if (sb.size() == 0) chk("sb_underflow", 1, 0);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.nm, "_rect"}, {28'd0, rect_read_func}, {28'd0, e.er});
            if (e.cv) chk({e.nm, "_vga"}, {28'd0, vga_cell_func}, {28'd0, e.ev});
         end
      end
   task automatic step(input logic [35:0] w, input logic [31:0] a, input int vx, input int vy,
                       input bit c, input logic [3:0] er, input logic [3:0] ev, input bit cv, input string nm);
      exp_t e;
      rect_write_in = w;
      rect_read_addr = a;
      vga_cell_x = 5'(vx);
      vga_cell_y = 5'(vy);
      clear = c;
      e.nm = nm; e.er = er; e.ev = ev; e.cv = cv;
      sb.push_back(e);
      pend = 1;
      @(negedge clk);
      pend = 0;
      clear = 0;
      rect_write_in = NOWR;
   endtask
   // counts sweep cycles while hammering an in-range write that must be ignored
   task automatic run_sweep(input int n0, input int lim, output int cnt);
      cnt = n0;
      while (busy && cnt < lim) begin
         rect_write_in = wr(10, 10, SNAKE);
         @(negedge clk);
         cnt++;
      end
      rect_write_in = NOWR;
   endtask
   initial begin
      #1_000_000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
   initial begin
      repeat (2) @(negedge clk);
      chk("rst_rect", {28'd0, rect_read_func}, 0);
      chk("rst_vga", {28'd0, vga_cell_func}, 0);
      chk("rst_busy", {31'd0, busy}, 1);
      rst_n = 1;
      run_sweep(0, 2000, n);
      chk("sweep_len_init", n, 768);
      step(NOWR, ad(5, 5), 5, 5, 0, NUL, NUL, 1, "init_5_5");
      step(NOWR, ad(0, 7), 0, 7, 0, BORDER, BORDER, 1, "init_0_7");
      step(wr(15, 15, SNAKE), ad(5, 5), 5, 5, 0, NUL, NUL, 1, "wr_15_15");
      step(NOWR, ad(15, 15), 15, 15, 0, SNAKE, SNAKE, 1, "rd_15_15");
      step(wr('hFFFF, 15, SNAKE), ad('hFFFF, 15), 31, 15, 0, ROCK, BORDER, 1, "oor_x");
      step(NOWR, ad(31, 15), 31, 15, 0, BORDER, BORDER, 1, "alias_31_15");
      step(wr(3, 'h0103, ROCK), ad(32, 0), 0, 0, 0, ROCK, BORDER, 1, "oor_32_0");
      step(NOWR, ad(3, 3), 3, 3, 0, NUL, NUL, 1, "alias_3_3");
      step(NOWR, ad(0, 24), 31, 24, 0, ROCK, NUL, 1, "oor_y24");
      step(wr(31, 23, SNAKE), ad(31, 23), 31, 23, 0, SNAKE, BORDER, 1, "corner_wf");
      step(NOWR, ad(31, 23), 31, 23, 0, SNAKE, SNAKE, 1, "corner_rd");
      step(wr(3, 4, SNACK), ad(3, 4), 3, 4, 0, SNACK, NUL, 1, "collide_3_4");
      step(NOWR, ad(3, 4), 3, 4, 0, SNACK, SNACK, 1, "rd_3_4");
      step(wr(10, 10, SNAKE), ad(10, 10), 10, 10, 0, SNAKE, NUL, 1, "wr_10_10");
      step(wr(20, 20, SNACK), ad(10, 10), 10, 10, 0, SNAKE, SNAKE, 1, "wr_20_20");
      step(NOWR, ad(20, 20), 20, 20, 1, SNACK, SNACK, 1, "clear_pulse");
      step(wr(10, 10, SNAKE), ad(10, 10), 20, 20, 0, NUL, SNACK, 1, "sweep_rd_null");
      step(NOWR, ad('hFFFF, 0), 0, 0, 0, ROCK, NUL, 0, "sweep_rd_oor");
      run_sweep(2, 2000, n);
      chk("sweep_len_clear", n, 768);
      step(NOWR, ad(10, 10), 10, 10, 0, NUL, NUL, 1, "cleared_10_10");
      step(NOWR, ad(15, 15), 31, 23, 0, NUL, BORDER, 1, "cleared_15_15");
      step(wr(20, 20, SNACK), ad(0, 0), 0, 0, 0, BORDER, BORDER, 1, "wr2_20_20");
      step(NOWR, ad(20, 20), 20, 20, 1, SNACK, SNACK, 1, "clear_pulse2");
      rect_read_addr = ad('hFFFF, 'hFFFF);
      run_sweep(0, 400, n);
      chk("sweep_reach_400", n, 400);
      chk("pre_rst_rect", {28'd0, rect_read_func}, {28'd0, ROCK});
      chk("pre_rst_vga", {28'd0, vga_cell_func}, {28'd0, SNACK});
      #2 rst_n = 0;
      #1;
      chk("async_rect", {28'd0, rect_read_func}, 0);
      chk("async_vga", {28'd0, vga_cell_func}, 0);
      chk("async_busy", {31'd0, busy}, 1);
      repeat (2) @(negedge clk);
      rst_n = 1;
      run_sweep(0, 2000, n);
      chk("sweep_len_rst", n, 768);
      step(NOWR, ad(20, 20), 20, 20, 0, NUL, NUL, 1, "after_rst_20_20");
      @(negedge clk);
      chk("sb_drain", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/grid_map.md
GRID_MAP -- requirements
Module: grid_map

Interface
REQ-001 SHALL have parameter GRID_SIZE_X, default 32, meaning grid columns (cell x range 0..31).
REQ-002 SHALL have parameter GRID_SIZE_Y, default 24, meaning grid rows (cell y range 0..23).
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port clear  input  1  synchronous request to restart the clear sweep.
REQ-006 SHALL have port rect_write_in  input  36  {x[35:20], y[19:4], func[3:0]}, write applied every cycle.
REQ-007 SHALL have port rect_read_addr  input  32  {x[31:16], y[15:0]}, game-logic read address.
REQ-008 SHALL have port rect_read_func  output  4  cell function for rect_read_addr.
REQ-009 SHALL have port vga_cell_x  input  5  display read column.
REQ-010 SHALL have port vga_cell_y  input  5  display read row.
REQ-011 SHALL have port vga_cell_func  output  4  cell function for the display read.
REQ-012 SHALL have port busy  output  1  high while the clear sweep runs.

Function
REQ-013 SHALL store GRID_SIZE_X*GRID_SIZE_Y 4-bit cells; index = {y[4:0], x[4:0]}, 0..767.
REQ-014 Cell codes SHALL be NULL=0000, SNAKE=0001, ROCK=0010, SNACK=0100; other codes stored unchanged.
REQ-015 SHALL have states SWEEP and IDLE; SWEEP -> IDLE after index 767 is written; IDLE -> SWEEP on clear=1.
REQ-016 In SWEEP, SHALL write one cell per cycle, index 0 to 767 ascending, with the sweep value (REQ-029/030); sweep takes exactly 768 cycles.
REQ-017 busy SHALL be 1 in every SWEEP cycle and 0 in IDLE.
REQ-018 clear=1 during SWEEP SHALL restart the sweep at index 0.
REQ-019 In IDLE, SHALL write func to the addressed cell every cycle when x<GRID_SIZE_X and y<GRID_SIZE_Y (full 16-bit compare).
REQ-020 Out-of-range write (any upper bits set, e.g. x=16'hFFFF) SHALL be discarded.
REQ-021 rect_write_in SHALL be ignored entirely during SWEEP.
REQ-022 rect_read_func SHALL be registered, latency 1 cycle from rect_read_addr.
REQ-023 Out-of-range rect_read_addr SHALL return ROCK (wall collision).
REQ-024 Read and write to the same in-range cell in the same cycle SHALL return the newly written func (write-first).
REQ-025 During SWEEP, rect_read_func SHALL return NULL for in-range addresses.
REQ-026 vga_cell_func SHALL be registered, latency 1 cycle; independent of the write path, read-first on collision.
REQ-027 vga_cell_x>=GRID_SIZE_X or vga_cell_y>=GRID_SIZE_Y SHALL return NULL.

Reset
REQ-028 rst_n=0 SHALL immediately force rect_read_func=0, vga_cell_func=0, sweep index=0, state=SWEEP, busy=1; after release the sweep runs as in REQ-016.

Configuration
REQ-029 Macro GRID_MAP_BORDER_ROCK_EN defined: sweep SHALL write ROCK to cells with x=0, x=GRID_SIZE_X-1, y=0 or y=GRID_SIZE_Y-1, NULL elsewhere.
REQ-030 Macro undefined: sweep SHALL write NULL to every cell; walls come only from REQ-023.

Verification
REQ-031 Release rst_n, hold clear=0 -> busy high exactly 768 cycles; then read (5,5) -> NULL; with macro read (0,7) -> ROCK, without -> NULL.
REQ-032 IDLE, write {16'd15,16'd15,SNAKE} one cycle, then read (15,15) -> SNAKE on next cycle; vga read (15,15) -> SNAKE.
REQ-033 IDLE, write {16'hFFFF,16'd15,SNAKE} -> no cell changes; read addr {16'hFFFF,16'd15} -> ROCK; read {16'd32,16'd0} -> ROCK.
REQ-034 Same cycle write (3,4)=SNACK and read (3,4) -> rect_read_func=SNACK; vga read (3,4) same cycle -> previous value.
REQ-035 Write (10,10)=SNAKE, pulse clear -> busy for 768 cycles, writes during sweep discarded, then (10,10) -> NULL.
REQ-036 Assert rst_n=0 mid-sweep at index 400 -> outputs 0 asynchronously; on release sweep restarts at 0 and lasts 768 cycles.
